multicycle_control_unit: RTL and testbench

//  FSM sequencer for the RV32I multi-cycle datapath. Steps each instruction through IDLE/FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK.

---
 rtl/multicycle_control_unit.sv | 196 +++++++++++++++++++
 tb/tb_multicycle_control_unit.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control_unit.sv
// rtl/multicycle_control_unit.sv - RV32I multi-cycle FSM sequencer with bus-timeout traps and retire counter
module multicycle_control_unit #(
  parameter int ACK_TIMEOUT = 255,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      instruction,
  input  logic             branch_taken,
  input  logic             imem_ack,
  input  logic             dmem_ack,
  output logic             imem_req,
  output logic             ir_write,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic [2:0]       imm_sel,
  output logic [1:0]       alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       wb_sel,
  output logic             reg_write,
  output logic             pc_write,
  output logic [1:0]       pc_sel,
  output logic             trap,
  output logic [1:0]       trap_cause,
  output logic [CNT_W-1:0] instret
);

  localparam int WAIT_W = $clog2(ACK_TIMEOUT + 1);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXECUTE, S_MEMORY, S_WRITEBACK, S_TRAP
  } state_t;

  state_t            state, next_state;
  logic [WAIT_W-1:0] wait_cnt;
  logic [1:0]        cause_q, next_cause;
  logic [CNT_W-1:0]  instret_q;
  logic [6:0]        opcode;
  logic [2:0]        imm_dec;
  logic              legal;
  logic              timed_out;
  logic              unused_instr_bits;

  assign opcode            = instruction[6:0];
  assign unused_instr_bits = ^instruction[31:7];
  // Last permitted wait cycle: an ack here still wins, otherwise we trap.
  assign timed_out         = (wait_cnt == WAIT_W'(ACK_TIMEOUT - 1));

  always_comb begin
    legal   = 1'b1;
    imm_dec = 3'd7;
    case (opcode)
      OPC_OP, OPC_FENCE:              imm_dec = 3'd7;
      OPC_OP_IMM, OPC_LOAD, OPC_JALR: imm_dec = 3'd0;
      OPC_STORE:                      imm_dec = 3'd1;
      OPC_BRANCH:                     imm_dec = 3'd2;
      OPC_LUI, OPC_AUIPC:             imm_dec = 3'd3;
      OPC_JAL:                        imm_dec = 3'd4;
      default:                        legal   = 1'b0;
    endcase
  end

  always_comb begin
    next_state = state;
    next_cause = cause_q;
    imem_req   = 1'b0;
    ir_write   = 1'b0;
    dmem_req   = 1'b0;
    dmem_we    = 1'b0;
    imm_sel    = 3'd7;
    alu_src_a  = 2'd0;
    alu_src_b  = 2'd0;
    wb_sel     = 2'd0;
    reg_write  = 1'b0;
    pc_write   = 1'b0;
    pc_sel     = 2'd0;
    case (state)
      S_IDLE: next_state = S_FETCH;
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          ir_write   = 1'b1;
          next_state = S_DECODE;
        end else if (timed_out) begin
          next_state = S_TRAP;
          next_cause = 2'd2;
        end
      end
      S_DECODE: begin
        imm_sel = imm_dec;
        if (legal) begin
          next_state = S_EXECUTE;
        end else begin
          next_state = S_TRAP;
          next_cause = 2'd1;
        end
      end
      S_EXECUTE: begin
        imm_sel = imm_dec;
        case (opcode)
          OPC_OP: next_state = S_WRITEBACK;
          OPC_OP_IMM, OPC_JAL, OPC_JALR: begin
            alu_src_b  = 2'd1;
            next_state = S_WRITEBACK;
          end
          OPC_LUI: begin
            alu_src_a  = 2'd2;
            alu_src_b  = 2'd1;
            next_state = S_WRITEBACK;
          end
          OPC_AUIPC: begin
            alu_src_a  = 2'd1;
            alu_src_b  = 2'd1;
            next_state = S_WRITEBACK;
          end
          OPC_LOAD, OPC_STORE: begin
            alu_src_b  = 2'd1;
            next_state = S_MEMORY;
          end
          OPC_BRANCH: begin
            pc_write   = 1'b1;
            pc_sel     = branch_taken ? 2'd1 : 2'd0;
            next_state = S_FETCH;
          end
          default: begin
            pc_write   = 1'b1;
            next_state = S_FETCH;
          end
        endcase
      end
      S_MEMORY: begin
        imm_sel  = imm_dec;
        dmem_req = 1'b1;
        dmem_we  = (opcode == OPC_STORE);
        if (dmem_ack) begin
          if (opcode == OPC_STORE) begin
            pc_write   = 1'b1;
            next_state = S_FETCH;
          end else begin
            next_state = S_WRITEBACK;
          end
        end else if (timed_out) begin
          next_state = S_TRAP;
          next_cause = 2'd3;
        end
      end
      S_WRITEBACK: begin
        imm_sel    = imm_dec;
        reg_write  = 1'b1;
        pc_write   = 1'b1;
        next_state = S_FETCH;
        if (opcode == OPC_JAL || opcode == OPC_JALR) wb_sel = 2'd2;
        else if (opcode == OPC_LOAD)                  wb_sel = 2'd1;
        if (opcode == OPC_JAL)       pc_sel = 2'd1;
        else if (opcode == OPC_JALR) pc_sel = 2'd2;
      end
      S_TRAP: next_state = S_TRAP;
      default: next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      wait_cnt  <= '0;
      cause_q   <= 2'd0;
      instret_q <= '0;
    end else begin
      state   <= next_state;
      cause_q <= next_cause;
      if (pc_write) instret_q <= instret_q + CNT_W'(1);
      if (next_state != state)
        wait_cnt <= '0;
      else if (state == S_FETCH || state == S_MEMORY)
        wait_cnt <= wait_cnt + WAIT_W'(1);
      else
        wait_cnt <= '0;
    end
  end

  assign trap       = (state == S_TRAP);
  assign trap_cause = cause_q;
  assign instret    = instret_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// tb/tb_multicycle_control_unit.sv - scoreboard bench for multicycle_control_unit
module tb_multicycle_control_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] instruction;
  logic        branch_taken, imem_ack, dmem_ack;
  logic        imem_req, ir_write, dmem_req, dmem_we, reg_write, pc_write, trap;
  logic [2:0]  imm_sel;
  logic [1:0]  alu_src_a, alu_src_b, wb_sel, pc_sel, trap_cause;
  logic [31:0] instret;

  multicycle_control_unit #(.ACK_TIMEOUT(4), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .instruction(instruction), .branch_taken(branch_taken),
    .imem_ack(imem_ack), .dmem_ack(dmem_ack), .imem_req(imem_req), .ir_write(ir_write),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .imm_sel(imm_sel), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .wb_sel(wb_sel), .reg_write(reg_write), .pc_write(pc_write),
    .pc_sel(pc_sel), .trap(trap), .trap_cause(trap_cause), .instret(instret)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic bound_fail(string name);
    n_chk++;
    n_fail++;
    $display("FAIL %s: got no response expected event within bound", name);
  endtask

  typedef struct {
    int is_trap; int cause; int pc_sel; int rw; int wb; int imm;
    int a; int b; int we; int lat; int dcnt; int ir;
  } exp_t;

  exp_t q[$];
  int   exp_ir = 0;

  task automatic push_i(int ps, int rw, int wb, int imm, int a, int b, int we, int lat, int dc);
    exp_t e;
    e.is_trap = 0; e.cause = 0; e.pc_sel = ps; e.rw = rw; e.wb = wb; e.imm = imm;
    e.a = a; e.b = b; e.we = we; e.lat = lat; e.dcnt = dc; e.ir = exp_ir;
    q.push_back(e);
    exp_ir++;
  endtask

  task automatic push_t(int cause);
    exp_t e;
    e.is_trap = 1; e.cause = cause; e.pc_sel = 0; e.rw = 0; e.wb = 0; e.imm = 7;
    e.a = 0; e.b = 0; e.we = 0; e.lat = 0; e.dcnt = 0; e.ir = 0;
    q.push_back(e);
  endtask

  // Monitor: retire events (pc_write) and trap entries are popped against the scoreboard
  int         fetch_cyc = 0;
  int         ir_cyc = -100;
  int         dcnt = 0;
  logic [1:0] a_cap = 2'd0, b_cap = 2'd0;
  logic       prev_req = 1'b0, prev_trap = 1'b0;

  always @(negedge clk) begin
    exp_t e;
    if (imem_req && !prev_req) begin
      fetch_cyc = cyc;
      dcnt = 0;
    end
    if (dmem_req) dcnt++;
    if (ir_write) ir_cyc = cyc;
    if (cyc == ir_cyc + 2) begin
      a_cap = alu_src_a;
      b_cap = alu_src_b;
    end
    if (pc_write) begin
      if (q.size() == 0) bound_fail("unexpected_retire");
      else begin
        e = q.pop_front();
        chk("event_kind", 32'd0, e.is_trap);
        chk("pc_sel", 32'(pc_sel), e.pc_sel);
        chk("reg_write", 32'(reg_write), e.rw);
        chk("wb_sel", 32'(wb_sel), e.wb);
        chk("imm_sel", 32'(imm_sel), e.imm);
        chk("dmem_we", 32'(dmem_we), e.we);
        chk("alu_src_a", 32'(a_cap), e.a);
        chk("alu_src_b", 32'(b_cap), e.b);
        chk("latency", cyc - fetch_cyc + 1, e.lat);
        chk("dmem_req_cycles", dcnt, e.dcnt);
        chk("instret", instret, e.ir);
      end
    end
    if (trap && !prev_trap) begin
      if (q.size() == 0) bound_fail("unexpected_trap");
      else begin
        e = q.pop_front();
        chk("event_kind", 32'd1, e.is_trap);
        chk("trap_cause", 32'(trap_cause), e.cause);
        chk("trap_imm_sel", 32'(imm_sel), e.imm);
      end
    end
    prev_req  = imem_req;
    prev_trap = trap;
  end

  // dwait: >=0 ack after that many extra cycles, -1 no memory phase, -2 never ack
  task automatic do_instr(logic [31:0] instr, logic br, int iwait, int dwait);
    int n;
    n = 0;
    while (!imem_req && n < 50) begin @(negedge clk); n++; end
    if (!imem_req) begin bound_fail("imem_req_wait"); return; end
    instruction  = instr;
    branch_taken = br;
    repeat (iwait) @(negedge clk);
    imem_ack = 1'b1;
    @(negedge clk);
    imem_ack = 1'b0;
    if (dwait != -1) begin
      n = 0;
      while (!dmem_req && n < 50) begin @(negedge clk); n++; end
      if (!dmem_req) begin bound_fail("dmem_req_wait"); return; end
      if (dwait >= 0) begin
        repeat (dwait) @(negedge clk);
        dmem_ack = 1'b1;
        @(negedge clk);
        dmem_ack = 1'b0;
      end
    end
  endtask

  task automatic wait_trap(string name);
    int n;
    n = 0;
    while (!trap && n < 20) begin @(negedge clk); n++; end
    if (!trap) bound_fail(name);
  endtask

  task automatic do_reset(string name);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk({name, "_trap"}, 32'(trap), 32'd0);
    chk({name, "_cause"}, 32'(trap_cause), 32'd0);
    chk({name, "_instret"}, instret, 32'd0);
    chk({name, "_imm_sel"}, 32'(imm_sel), 32'd7);
    exp_ir = 0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int n;
    logic bad;
    instruction = 32'h0; branch_taken = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_imm_sel", 32'(imm_sel), 32'd7);
    chk("rst_strobes", 32'({imem_req, ir_write, dmem_req, dmem_we, reg_write, pc_write}), 32'd0);
    chk("rst_muxes", 32'({alu_src_a, alu_src_b, wb_sel, pc_sel}), 32'd0);
    chk("rst_trap", 32'({trap, trap_cause}), 32'd0);
    chk("rst_instret", instret, 32'd0);
    rst_n = 1'b1;

    push_i(0, 1, 0, 0, 0, 1, 0, 4, 0); do_instr(32'h00500093, 1'b0, 0, -1);  // ADDI
    push_i(0, 1, 1, 0, 0, 1, 0, 8, 4); do_instr(32'h0000A103, 1'b0, 0, 3);   // LW, late ack
    push_i(0, 1, 1, 0, 0, 1, 0, 5, 1); do_instr(32'h00412183, 1'b0, 0, 0);   // LW, zero wait
    push_i(1, 0, 0, 2, 0, 0, 0, 3, 0); do_instr(32'h00208463, 1'b1, 0, -1);  // BEQ taken
    push_i(0, 0, 0, 2, 0, 0, 0, 3, 0); do_instr(32'h00208463, 1'b0, 0, -1);  // BEQ not taken
    push_i(1, 1, 2, 4, 0, 1, 0, 4, 0); do_instr(32'h008000EF, 1'b0, 0, -1);  // JAL
    push_i(2, 1, 2, 0, 0, 1, 0, 4, 0); do_instr(32'h000080E7, 1'b0, 0, -1);  // JALR
    push_i(0, 0, 0, 1, 0, 1, 1, 7, 1); do_instr(32'h00112223, 1'b0, 3, 0);   // SW, imem ack on last cycle
    push_i(0, 1, 0, 3, 2, 1, 0, 4, 0); do_instr(32'h123450B7, 1'b0, 0, -1);  // LUI
    push_i(0, 1, 0, 3, 1, 1, 0, 4, 0); do_instr(32'h00000097, 1'b0, 0, -1);  // AUIPC
    push_i(0, 0, 0, 7, 0, 0, 0, 3, 0); do_instr(32'h0000000F, 1'b0, 0, -1);  // FENCE
    push_i(0, 1, 0, 7, 0, 0, 0, 4, 0); do_instr(32'h002081B3, 1'b0, 0, -1);  // ADD

    push_t(1);
    do_instr(32'h0000007F, 1'b0, 0, -1);
    wait_trap("illegal_trap_wait");
    bad = 1'b0;
    for (int i = 0; i < 20; i++) begin
      imem_ack = i[0];
      dmem_ack = i[1];
      @(negedge clk);
      if (imem_req || dmem_req || ir_write || reg_write || pc_write || !trap || imm_sel != 3'd7)
        bad = 1'b1;
    end
    imem_ack = 1'b0; dmem_ack = 1'b0;
    chk("trap_quiet", 32'(bad), 32'd0);
    chk("trap_cause_held", 32'(trap_cause), 32'd1);
    chk("instret_frozen", instret, 32'd12);
    do_reset("reset1");

    push_t(2);
    n = 0;
    while (!imem_req && n < 50) begin @(negedge clk); n++; end
    n = 0;
    while (imem_req && n < 20) begin n++; @(negedge clk); end
    chk("imem_timeout_req_cycles", n, 32'd4);
    wait_trap("imem_timeout_wait");
    do_reset("reset2");

    push_t(3);
    do_instr(32'h0000A103, 1'b0, 0, -2);
    wait_trap("dmem_timeout_wait");
    do_reset("reset3");

    push_i(0, 1, 0, 0, 0, 1, 0, 4, 0); do_instr(32'h00500093, 1'b0, 0, -1);
    do_instr(32'h0000A103, 1'b0, 0, -2);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_dmem_req", 32'(dmem_req), 32'd0);
    chk("async_rst_imem_req", 32'(imem_req), 32'd0);
    chk("async_rst_instret", instret, 32'd0);
    repeat (2) @(negedge clk);
    chk("scoreboard_drained", q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
